sample_decimator: RTL

Upstream stage of the echo/delay path. Takes full-rate 48 kHz signed codec samples, low-pass filters them with a power-of-two boxcar FIR, and decimates by 2. It emits one 12-bit signed sample with a one-cycle `start` pulse, which is exactly the input handshake the delay stage consumes. It also monitors the downstream `done` line and flags overruns.

---
 rtl/audio_pkg.sv | 15 +
 rtl/sample_history.sv | 29 ++
 rtl/sample_decimator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: codec/sample widths, sample type and decimator states.
package audio_pkg;

    localparam int AC97_WIDTH   = 20;
    localparam int SAMPLE_WIDTH = 12;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND
    } decimState_t;

endpackage

// File: rtl/sample_history.sv
// Circular history of the most recent codec samples feeding the boxcar FIR.
// Write pointer wrap is owned by the parent; reads are combinational.
module sample_history #(
    parameter int TAPS  = 4,
    parameter int WIDTH = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(TAPS)-1:0] wr_ptr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [$clog2(TAPS)-1:0] rd_idx,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] r_mem [TAPS];

    // Synchronous clear so ramp-up after reset always starts from silence
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else if (we) begin
            r_mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule

// File: rtl/sample_decimator.sv
// Boxcar low-pass and decimate codec samples, then hand each result to the delay
// stage with a one-cycle start pulse; overruns on either side raise a sticky flag.
module sample_decimator
    import audio_pkg::*;
#(
    parameter int IN_WIDTH  = AC97_WIDTH,
    parameter int OUT_WIDTH = SAMPLE_WIDTH,
    parameter int TAPS      = 4,
    parameter int DECIMATE  = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ready,
    input  logic signed [IN_WIDTH-1:0]  from_codec,
    input  logic                        downstream_done,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        start,
    output logic                        overrun
);

    localparam int LOG2_TAPS = $clog2(TAPS);
    localparam int ACC_W     = IN_WIDTH + LOG2_TAPS;
    localparam int SHIFT     = IN_WIDTH - OUT_WIDTH;
    localparam int PHASE_W   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    localparam logic signed [ACC_W-1:0] ROUND_OFFSET = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX      = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN      = -SAT_MAX - ACC_W'(1);

    decimState_t                    r_state;
    logic [LOG2_TAPS-1:0]           r_wrPtr;
    logic [LOG2_TAPS-1:0]           r_idx;
    logic [PHASE_W-1:0]             r_phase;
    logic                           r_pending;
    logic signed [IN_WIDTH-1:0]     r_hold;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [OUT_WIDTH-1:0]    r_sampleOut;
    logic                           r_start;
    logic                           r_overrun;

    logic                           w_histWe;
    logic signed [IN_WIDTH-1:0]     w_histWrData;
    logic signed [IN_WIDTH-1:0]     w_histRd;
    logic signed [ACC_W-1:0]        w_histExt;
    logic signed [ACC_W-1:0]        w_mean;
    logic signed [ACC_W-1:0]        w_shifted;
    logic signed [OUT_WIDTH-1:0]    w_sat;

    // A held sample always takes priority over a fresh one arriving in the same cycle
    always_comb begin
        w_histWe     = (r_state == IDLE) && (ready || r_pending);
        w_histWrData = r_pending ? r_hold : from_codec;
        w_histExt    = ACC_W'(w_histRd);
    end

    sample_history #(
        .TAPS  (TAPS),
        .WIDTH (IN_WIDTH)
    ) u_history (
        .clock   (clock),
        .reset   (reset),
        .we      (w_histWe),
        .wr_ptr  (r_wrPtr),
        .wr_data (w_histWrData),
        .rd_idx  (r_idx),
        .rd_data (w_histRd)
    );

    // Mean, round half up into the narrower format, then clamp to its range
    always_comb begin
        w_mean    = r_acc >>> LOG2_TAPS;
        w_shifted = (w_mean + ROUND_OFFSET) >>> SHIFT;
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            w_sat = w_shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wrPtr     <= '0;
            r_idx       <= '0;
            r_phase     <= '0;
            r_pending   <= 1'b0;
            r_hold      <= '0;
            r_acc       <= '0;
            r_sampleOut <= '0;
            r_start     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (ready && r_pending) begin
                r_overrun <= 1'b1;
            end

            // Holding register: refilled by any ready that cannot be written directly
            if (r_state == IDLE) begin
                if (r_pending) begin
                    if (ready) begin
                        r_hold <= from_codec;
                    end else begin
                        r_pending <= 1'b0;
                    end
                end
            end else if (ready) begin
                r_hold    <= from_codec;
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_histWe) begin
                        r_wrPtr <= r_wrPtr + LOG2_TAPS'(1);
                        if (r_phase == PHASE_W'(DECIMATE - 1)) begin
                            r_phase <= '0;
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_state <= ACCUM;
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + w_histExt;
                    r_idx <= r_idx + LOG2_TAPS'(1);
                    if (r_idx == LOG2_TAPS'(TAPS - 1)) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_sampleOut <= w_sat;
                    r_start     <= 1'b1;
                    if (!downstream_done) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sample_out = r_sampleOut;
    assign start      = r_start;
    assign overrun    = r_overrun;

endmodule
